// File: rtl/lookahead_buffer.sv
// -----------------------------------------------------------------------------
// tpu_pkg / lookahead_buffer
//
// Purpose:
//   Two-stage instruction buffer that sits between the TPU instruction FIFO and
//   the control coordinator. An instruction is captured in an input stage and
//   then moved into a registered output stage.
//
//   A load-weight instruction is not released by itself. It stays in the input
//   stage until the next instruction is written. On that same edge the weight
//   load is issued, so it reaches the coordinator directly ahead of the
//   instruction that consumes the weights.
//
// Ports:
//   clk          in   1           clock; all state changes on the rising edge
//   rst          in   1           asynchronous, active-high reset
//   enable       in   1           global advance enable; low freezes all state
//   instr_busy   in   1           downstream busy; high stalls the buffer
//   instr_in     in   instr_type  incoming instruction
//   instr_write  in   1           instr_in valid strobe, one cycle per instr
//   instr_out    out  instr_type  registered output instruction
//   instr_read   out  1           one-cycle strobe: instr_out holds a new instr
// -----------------------------------------------------------------------------

package tpu_pkg;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  flags;
    logic [15:0] length;
    logic [31:0] addr;
  } instr_type;

  localparam instr_type   INIT_INSTR  = '0;
  localparam logic [7:0]  LOAD_WEIGHT = 8'h08;

endpackage

module lookahead_buffer
  import tpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      enable,
  input  logic      instr_busy,
  input  instr_type instr_in,
  input  logic      instr_write,
  output instr_type instr_out,
  output logic      instr_read
);

  instr_type in_reg;
  logic      in_valid;
  logic      adv;
  logic      do_release;

  // The whole buffer advances only when enabled and downstream can accept.
  assign adv = enable & ~instr_busy;

  // A buffered instruction leaves the input stage unless it is a weight load
  // still waiting for its consumer. The consumer's write releases the weight
  // load on the same edge it is captured, so streaming has no bubbles.
  assign do_release = in_valid & ((in_reg.opcode != LOAD_WEIGHT) | instr_write);

  // Output stage: instr_read is a one-cycle strobe and is cleared on any edge
  // that does not transfer, including stalled edges. instr_out keeps its last
  // value when nothing is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_out  <= INIT_INSTR;
      instr_read <= 1'b0;
    end else if (adv && do_release) begin
      instr_out  <= in_reg;
      instr_read <= 1'b1;
    end else begin
      instr_read <= 1'b0;
    end
  end

  // Input stage: a new write always takes the slot, since any occupant is
  // released on that same edge. Writes arriving while stalled are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_reg   <= INIT_INSTR;
      in_valid <= 1'b0;
    end else if (adv) begin
      if (instr_write) begin
        in_reg   <= instr_in;
        in_valid <= 1'b1;
      end else if (do_release) begin
        in_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lookahead_buffer.sv
// -----------------------------------------------------------------------------
// tb_lookahead_buffer
//
// Purpose:
//   Self-checking bench for lookahead_buffer. Written instructions are pushed to
//   an expected queue; a monitor captures every instr_read pulse, and each test
//   compares captured against expected in order, plus cycle-level pulse checks.
// -----------------------------------------------------------------------------

module tb_lookahead_buffer;
  import tpu_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      enable = 1'b1;
  logic      instr_busy = 1'b0;
  instr_type instr_in = '0;
  logic      instr_write = 1'b0;
  instr_type instr_out;
  logic      instr_read;

  int tests_run = 0;
  int tests_failed = 0;

  instr_type exp_q[$];
  instr_type got_q[$];

  lookahead_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .instr_busy  (instr_busy),
    .instr_in    (instr_in),
    .instr_write (instr_write),
    .instr_out   (instr_out),
    .instr_read  (instr_read)
  );

  always #5 clk = ~clk;

  // Capture every output pulse half a cycle after the edge that produced it.
  always @(negedge clk) begin
    if (instr_read === 1'b1) got_q.push_back(instr_out);
  end

  function automatic instr_type mk(input logic [7:0] op);
    instr_type t;
    t.opcode = op;
    t.flags  = 8'($urandom);
    t.length = 16'($urandom);
    t.addr   = $urandom;
    return t;
  endfunction

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for one edge, optionally recording it as expected.
  task automatic wr(input instr_type t, input bit expect_out);
    instr_in    = t;
    instr_write = 1'b1;
    if (expect_out) exp_q.push_back(t);
    step();
    instr_write = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (instr_read !== 1'b0 || instr_out !== INIT_INSTR) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: read=%b out=%h, expected read=0 out=%h",
               instr_read, instr_out, INIT_INSTR);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (instr_read !== 1'b0 || instr_out !== INIT_INSTR) begin
        tests_failed++;
        $display("[TB] FAIL reset_idle[%0d]: read=%b out=%h, expected read=0 out=%h",
                 i, instr_read, instr_out, INIT_INSTR);
      end
    end
  endtask

  task automatic test_single();
    instr_type a;
    a = mk(8'h20);
    wr(a, 1'b1);
    tests_run++;
    if (instr_read !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_early: read=%b, expected 0", instr_read);
    end
    step();
    tests_run++;
    if (instr_read !== 1'b1 || instr_out !== a) begin
      tests_failed++;
      $display("[TB] FAIL single_pulse: read=%b out=%h, expected read=1 out=%h",
               instr_read, instr_out, a);
    end
    step();
    tests_run++;
    if (instr_read !== 1'b0 || instr_out !== a) begin
      tests_failed++;
      $display("[TB] FAIL single_hold: read=%b out=%h, expected read=0 out=%h",
               instr_read, instr_out, a);
    end
  endtask

  // Weight held on idle, then released by a write; continues into a
  // back-to-back pair and a busy stall on the last instruction.
  task automatic test_weight_and_busy();
    instr_type w, b, c, d;
    w = mk(8'h08);
    b = mk(8'h20);
    c = mk(8'h80);
    d = mk(8'h20);
    wr(w, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      tests_run++;
      if (instr_read !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL weight_held[%0d]: read=%b, expected 0", i, instr_read);
      end
    end
    wr(b, 1'b1);
    tests_run++;
    if (instr_read !== 1'b1 || instr_out !== w) begin
      tests_failed++;
      $display("[TB] FAIL weight_release: read=%b out=%h, expected read=1 out=%h",
               instr_read, instr_out, w);
    end
    wr(c, 1'b1);
    tests_run++;
    if (instr_read !== 1'b1 || instr_out !== b) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: read=%b out=%h, expected read=1 out=%h",
               instr_read, instr_out, b);
    end
    wr(d, 1'b1);
    tests_run++;
    if (instr_read !== 1'b1 || instr_out !== c) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: read=%b out=%h, expected read=1 out=%h",
               instr_read, instr_out, c);
    end
    instr_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (instr_read !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL busy_stall[%0d]: read=%b, expected 0", i, instr_read);
      end
    end
    instr_busy = 1'b0;
    step();
    tests_run++;
    if (instr_read !== 1'b1 || instr_out !== d) begin
      tests_failed++;
      $display("[TB] FAIL busy_resume: read=%b out=%h, expected read=1 out=%h",
               instr_read, instr_out, d);
    end
    step();
    tests_run++;
    if (instr_read !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL busy_after: read=%b, expected 0", instr_read);
    end
  endtask

  // Two weights followed by a consumer, with an enable freeze in the middle.
  task automatic test_back_to_back();
    instr_type w1, w2, e;
    w1 = mk(8'h08);
    w2 = mk(8'h08);
    e  = mk(8'h20);
    wr(w1, 1'b1);
    wr(w2, 1'b1);
    tests_run++;
    if (instr_read !== 1'b1 || instr_out !== w1) begin
      tests_failed++;
      $display("[TB] FAIL chain_w1: read=%b out=%h, expected read=1 out=%h",
               instr_read, instr_out, w1);
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (instr_read !== 1'b0 || instr_out !== w1) begin
        tests_failed++;
        $display("[TB] FAIL freeze[%0d]: read=%b out=%h, expected read=0 out=%h",
                 i, instr_read, instr_out, w1);
      end
    end
    enable = 1'b1;
    wr(e, 1'b1);
    tests_run++;
    if (instr_read !== 1'b1 || instr_out !== w2) begin
      tests_failed++;
      $display("[TB] FAIL chain_w2: read=%b out=%h, expected read=1 out=%h",
               instr_read, instr_out, w2);
    end
    step();
    tests_run++;
    if (instr_read !== 1'b1 || instr_out !== e) begin
      tests_failed++;
      $display("[TB] FAIL chain_e: read=%b out=%h, expected read=1 out=%h",
               instr_read, instr_out, e);
    end
    step();
  endtask

  // A write presented while enable is low must vanish.
  task automatic test_dropped_write();
    enable = 1'b0;
    wr(mk(8'h40), 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (instr_read !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL dropped_write[%0d]: read=%b, expected 0", i, instr_read);
      end
    end
  endtask

  // Async reset mid-stream discards a held weight instruction.
  task automatic test_reset_mid();
    instr_type a, w, f;
    a = mk(8'h20);
    w = mk(8'h08);
    f = mk(8'h30);
    wr(a, 1'b0);
    wr(w, 1'b0);
    tests_run++;
    if (instr_read !== 1'b1 || instr_out !== a) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset: read=%b out=%h, expected read=1 out=%h",
               instr_read, instr_out, a);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (instr_read !== 1'b0 || instr_out !== INIT_INSTR) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: read=%b out=%h, expected read=0 out=%h",
               instr_read, instr_out, INIT_INSTR);
    end
    step();
    rst = 1'b0;
    wr(f, 1'b1);
    step();
    tests_run++;
    if (instr_read !== 1'b1 || instr_out !== f) begin
      tests_failed++;
      $display("[TB] FAIL post_reset: read=%b out=%h, expected read=1 out=%h",
               instr_read, instr_out, f);
    end
    step();
  endtask

  // Compare every captured pulse against the expected order.
  task automatic test_scoreboard();
    instr_type g, x;
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL sb_extra: got=%h, expected no output", g);
      end else begin
        x = exp_q.pop_front();
        if (g !== x) begin
          tests_failed++;
          $display("[TB] FAIL sb_order: got=%h, expected %h", g, x);
        end
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL sb_missing: got %0d outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_weight_and_busy();
    test_back_to_back();
    test_dropped_write();
    test_reset_mid();
    test_scoreboard();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
